// File: rtl/adc_sample_sequencer.sv
// ---------------------------------------------------------------------------
// adc_sample_sequencer
//
// Periodically runs a 16-bit SPI frame against a 10-bit serial ADC and hands
// each conversion to a downstream consumer over a valid/ready handshake.
//
// A free-running tick counter triggers a frame every SAMPLE_PERIOD clk cycles
// while enable is high.  A frame drives a 4-bit command (start, single-ended,
// channel, MSB-first) on doutAdc and captures ten result bits from dinAdc.
// A tick that cannot start a frame, because a frame is already running or an
// unaccepted sample is still pending, is counted in overrunCount.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset
//   enable       1 = periodic sampling runs, 0 = no new frames start
//   chanSel      ADC channel for the next frame, latched at frame start
//   dinAdc       serial data from the ADC
//   sclkAdc      SPI clock to the ADC, idles low
//   doutAdc      serial command to the ADC
//   ncsAdc       active-low chip select to the ADC
//   sampleData   last captured 10-bit conversion
//   sampleChan   channel that sampleData was taken from
//   sampleValid  sample pending for the downstream consumer
//   sampleReady  downstream accepts when sampleValid && sampleReady
//   overrunCount saturating count of skipped ticks
//   busy         high from frame start through the end of HOLD
// ---------------------------------------------------------------------------
module adc_sample_sequencer #(
   parameter int CLK_DIV       = 8,
   parameter int SAMPLE_PERIOD = 2500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       chanSel,
   input  logic       dinAdc,
   output logic       sclkAdc,
   output logic       doutAdc,
   output logic       ncsAdc,
   output logic [9:0] sampleData,
   output logic       sampleChan,
   output logic       sampleValid,
   input  logic       sampleReady,
   output logic [7:0] overrunCount,
   output logic       busy
);

   localparam int                TICK_W    = $clog2(SAMPLE_PERIOD);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
   localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [7:0]        div_cnt_q, div_cnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [9:0]        shift_q, shift_d;
   logic              chan_q, chan_d;
   logic              sclk_q, sclk_d;
   logic              dout_q, dout_d;
   logic              ncs_q, ncs_d;
   logic [9:0]        sample_data_q, sample_data_d;
   logic              sample_chan_q, sample_chan_d;
   logic              sample_valid_q, sample_valid_d;
   logic [7:0]        overrun_q, overrun_d;

   logic              tick;
   logic              overrun;
   logic [15:0]       cmd_word;
   logic [3:0]        bit_next;

   // State register; reset puts the ADC bus in its idle, deselected state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         tick_cnt_q     <= '0;
         div_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         chan_q         <= 1'b0;
         sclk_q         <= 1'b0;
         dout_q         <= 1'b0;
         ncs_q          <= 1'b1;
         sample_data_q  <= '0;
         sample_chan_q  <= 1'b0;
         sample_valid_q <= 1'b0;
         overrun_q      <= '0;
      end else begin
         state_q        <= state_d;
         tick_cnt_q     <= tick_cnt_d;
         div_cnt_q      <= div_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         chan_q         <= chan_d;
         sclk_q         <= sclk_d;
         dout_q         <= dout_d;
         ncs_q          <= ncs_d;
         sample_data_q  <= sample_data_d;
         sample_chan_q  <= sample_chan_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
      end
   end

   // Next-state logic: tick generation, frame sequencing, handshake and
   // overrun accounting.
   always_comb begin
      state_d        = state_q;
      tick_cnt_d     = tick_cnt_q;
      div_cnt_d      = div_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      chan_d         = chan_q;
      sclk_d         = sclk_q;
      dout_d         = dout_q;
      ncs_d          = ncs_q;
      sample_data_d  = sample_data_q;
      sample_chan_d  = sample_chan_q;
      sample_valid_d = sample_valid_q;
      overrun_d      = overrun_q;
      overrun        = 1'b0;

      // Command bits in wire order: bit 0 is sent first.
      cmd_word = {12'h000, 1'b1, chan_q, 2'b11};
      bit_next = bit_cnt_q + 4'd1;

      // Tick counter rests at zero while disabled so the first tick after
      // enabling is a full period away.
      tick = enable && (tick_cnt_q == TICK_LAST);
      if (!enable || (tick_cnt_q == TICK_LAST)) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end

      if (sample_valid_q && sampleReady) begin
         sample_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               // A pending sample blocks the frame so it is never overwritten.
               if (!sample_valid_q) begin
                  state_d   = ST_SHIFT;
                  chan_d    = chanSel;
                  ncs_d     = 1'b0;
                  sclk_d    = 1'b0;
                  dout_d    = 1'b1;
                  div_cnt_d = '0;
                  bit_cnt_d = '0;
               end else begin
                  overrun = 1'b1;
               end
            end
         end

         ST_SHIFT: begin
            overrun = tick;
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  // Rising edge: only bits 6..15 carry conversion data.
                  sclk_d = 1'b1;
                  if (bit_cnt_q >= 4'd6) begin
                     shift_d = {shift_q[8:0], dinAdc};
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == 4'd15) begin
                     state_d        = ST_HOLD;
                     ncs_d          = 1'b1;
                     dout_d         = 1'b0;
                     sample_data_d  = shift_q;
                     sample_chan_d  = chan_q;
                     sample_valid_d = 1'b1;
                  end else begin
                     bit_cnt_d = bit_next;
                     dout_d    = cmd_word[bit_next];
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         ST_HOLD: begin
            // Keeps chip select high for the ADC's minimum deselect time.
            overrun = tick;
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               div_cnt_d = div_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (overrun && (overrun_q != 8'hFF)) begin
         overrun_d = overrun_q + 8'd1;
      end
   end

   assign sclkAdc      = sclk_q;
   assign doutAdc      = dout_q;
   assign ncsAdc       = ncs_q;
   assign sampleData   = sample_data_q;
   assign sampleChan   = sample_chan_q;
   assign sampleValid  = sample_valid_q;
   assign overrunCount = overrun_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_sequencer
//
// Self-checking bench for adc_sample_sequencer with CLK_DIV = 2 and
// SAMPLE_PERIOD = 100.  A behavioural ADC model drives dinAdc from adc_word
// and records the command bits seen on doutAdc at each sclkAdc rising edge.
// A table of frame vectors covers the normal sampling path; hand-written
// sequences cover overrun, reset mid-frame, enable drop and saturation.
// ---------------------------------------------------------------------------
module tb_adc_sample_sequencer;

   localparam int CD = 2;
   localparam int SP = 100;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       chan_sel;
   logic       din_adc;
   logic       sclk_adc;
   logic       dout_adc;
   logic       ncs_adc;
   logic [9:0] sample_data;
   logic       sample_chan;
   logic       sample_valid;
   logic       sample_ready;
   logic [7:0] overrun_count;
   logic       busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // ADC model and bus monitor state
   logic [9:0]  adc_word      = '0;
   logic [15:0] cmd_seen      = '0;
   int          rise_cnt      = 0;
   int          ncs_fall_cyc  = 0;
   int          ncs_rise_cyc  = 0;
   int          ncs_low_len   = 0;
   int          valid_rise_cyc = 0;
   int          frames_started = 0;
   int          samples_seen   = 0;
   logic        ncs_prev   = 1'b1;
   logic        sclk_prev  = 1'b0;
   logic        valid_prev = 1'b0;

   typedef struct {
      logic        chan;
      logic [9:0]  word;
      logic [9:0]  exp_data;
      logic        exp_chan;
      logic [15:0] exp_cmd;
   } vec_t;

   vec_t vecs[4];

   adc_sample_sequencer #(
      .CLK_DIV      (CD),
      .SAMPLE_PERIOD(SP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .chanSel     (chan_sel),
      .dinAdc      (din_adc),
      .sclkAdc     (sclk_adc),
      .doutAdc     (dout_adc),
      .ncsAdc      (ncs_adc),
      .sampleData  (sample_data),
      .sampleChan  (sample_chan),
      .sampleValid (sample_valid),
      .sampleReady (sample_ready),
      .overrunCount(overrun_count),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // ADC model: presents result bit k before the k-th rising sclk edge
   // (bits 6..15 carry adc_word MSB first) and logs the command bit on each
   // rising edge.  Runs on the falling clk edge, away from DUT updates.
   always @(negedge clk) begin
      if (!ncs_adc && ncs_prev) begin
         ncs_fall_cyc = cyc;
         frames_started++;
         rise_cnt = 0;
         cmd_seen = '0;
      end
      if (ncs_adc && !ncs_prev) begin
         ncs_rise_cyc = cyc;
         ncs_low_len  = cyc - ncs_fall_cyc;
      end
      if (sample_valid && !valid_prev) begin
         valid_rise_cyc = cyc;
         samples_seen++;
      end
      if (!ncs_adc && sclk_adc && !sclk_prev) begin
         if (rise_cnt < 16) cmd_seen[rise_cnt] = dout_adc;
         rise_cnt++;
      end
      if (!ncs_adc && rise_cnt >= 6 && rise_cnt <= 15) din_adc = adc_word[15 - rise_cnt];
      else din_adc = 1'b0;
      ncs_prev   = ncs_adc;
      sclk_prev  = sclk_adc;
      valid_prev = sample_valid;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic ch, input logic rdy);
      reset        = rst;
      enable       = en;
      chan_sel     = ch;
      sample_ready = rdy;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic timeoutFail(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   // Waits for ncsAdc to fall and returns the cycle of the starting edge.
   task automatic waitFrameStart(input string name, output int start_cyc);
      int n;
      start_cyc = -1;
      n = 0;
      while (!ncs_adc && n < 400) begin step(); n++; end
      while (ncs_adc && n < 400) begin step(); n++; end
      if (ncs_adc) timeoutFail(name);
      else start_cyc = cyc;
   endtask

   task automatic waitValid(input string name);
      int n;
      n = 0;
      while (!sample_valid && n < 400) begin step(); n++; end
      if (!sample_valid) timeoutFail(name);
   endtask

   task automatic countRises(input string name, input int target);
      int   seen;
      int   n;
      logic prev;
      seen = 0;
      n    = 0;
      prev = sclk_adc;
      while (seen < target && n < 400) begin
         step();
         n++;
         if (sclk_adc && !prev) seen++;
         prev = sclk_adc;
      end
      if (seen < target) timeoutFail(name);
   endtask

   initial begin
      int r_cyc;
      int f_cyc;
      int t1;
      int t2;
      int snap;
      int snap2;

      vecs[0] = '{chan: 1'b1, word: 10'h2A5, exp_data: 10'h2A5, exp_chan: 1'b1, exp_cmd: 16'h000F};
      vecs[1] = '{chan: 1'b0, word: 10'h15A, exp_data: 10'h15A, exp_chan: 1'b0, exp_cmd: 16'h000B};
      vecs[2] = '{chan: 1'b1, word: 10'h3FF, exp_data: 10'h3FF, exp_chan: 1'b1, exp_cmd: 16'h000F};
      vecs[3] = '{chan: 1'b0, word: 10'h001, exp_data: 10'h001, exp_chan: 1'b0, exp_cmd: 16'h000B};

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      checkOutput("rst_ncs", ncs_adc, 1);
      checkOutput("rst_sclk", sclk_adc, 0);
      checkOutput("rst_dout", dout_adc, 0);
      checkOutput("rst_valid", sample_valid, 0);
      checkOutput("rst_data", sample_data, 0);
      checkOutput("rst_chan", sample_chan, 0);
      checkOutput("rst_overrun", overrun_count, 0);
      checkOutput("rst_busy", busy, 0);

      // Release reset with sampling enabled; r_cyc is the last reset edge.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      r_cyc = cyc;

      // Table-driven frames, each accepted after inspection
      for (int i = 0; i < 4; i++) begin
         chan_sel = vecs[i].chan;
         adc_word = vecs[i].word;
         waitFrameStart("frame_start", f_cyc);
         if (i == 0) checkOutput("first_tick_latency", f_cyc - r_cyc, SP);
         else checkOutput("frame_spacing", f_cyc - r_cyc, SP * (i + 1));
         chan_sel = ~vecs[i].chan;
         waitValid("frame_valid");
         @(negedge clk);
         #1;
         checkOutput("ncs_low_len", ncs_low_len, 32 * CD);
         checkOutput("cmd_bits", cmd_seen, vecs[i].exp_cmd);
         checkOutput("sample_data", sample_data, vecs[i].exp_data);
         checkOutput("sample_chan", sample_chan, vecs[i].exp_chan);
         checkOutput("valid_with_ncs", valid_rise_cyc, ncs_rise_cyc);
         checkOutput("busy_in_hold", busy, 1);
         step();
         sample_ready = 1'b1;
         step();
         checkOutput("handshake_clear", sample_valid, 0);
         checkOutput("idle_after_hold", busy, 0);
         sample_ready = 1'b0;
      end
      checkOutput("no_overrun_table", overrun_count, 0);

      // Held sample blocks three ticks
      chan_sel = 1'b0;
      adc_word = 10'h1C3;
      waitFrameStart("ovr_frame_start", f_cyc);
      waitValid("ovr_valid");
      @(negedge clk);
      snap = frames_started;
      step();
      repeat (300) step();
      checkOutput("overrun_3", overrun_count, 3);
      checkOutput("no_new_frames", frames_started, snap);
      checkOutput("data_held", sample_data, 10'h1C3);
      checkOutput("valid_held", sample_valid, 1);
      sample_ready = 1'b1;
      step();
      checkOutput("late_handshake_clear", sample_valid, 0);
      sample_ready = 1'b0;
      waitFrameStart("resume_frame_start", t1);
      checkOutput("resume_on_next_tick", t1 - f_cyc, 4 * SP);
      waitValid("resume_valid");
      sample_ready = 1'b1;
      step();
      sample_ready = 1'b0;

      // Back-to-back samples with ready held high
      adc_word     = 10'h3FF;
      sample_ready = 1'b1;
      waitValid("b2b_valid_1");
      t1 = cyc;
      checkOutput("b2b_data_1", sample_data, 10'h3FF);
      adc_word = 10'h000;
      step();
      checkOutput("b2b_one_cycle", sample_valid, 0);
      waitValid("b2b_valid_2");
      t2 = cyc;
      checkOutput("b2b_spacing", t2 - t1, SP);
      checkOutput("b2b_data_2", sample_data, 10'h000);

      // Enable dropped mid-frame: frame still completes
      adc_word = 10'h2C7;
      waitFrameStart("endrop_frame_start", f_cyc);
      countRises("endrop_rises", 10);
      enable = 1'b0;
      waitValid("endrop_valid");
      checkOutput("endrop_data", sample_data, 10'h2C7);
      @(negedge clk);
      snap  = frames_started;
      snap2 = overrun_count;
      repeat (300) step();
      checkOutput("endrop_no_frames", frames_started, snap);
      checkOutput("endrop_overrun", overrun_count, snap2);
      checkOutput("endrop_ncs_idle", ncs_adc, 1);
      checkOutput("endrop_busy", busy, 0);

      // Reset at the seventh sclk rising edge of a frame
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      adc_word = 10'h155;
      waitFrameStart("rstmid_frame_start", f_cyc);
      countRises("rstmid_rises", 7);
      snap   = samples_seen;
      reset  = 1'b1;
      step();
      checkOutput("rstmid_ncs", ncs_adc, 1);
      checkOutput("rstmid_valid", sample_valid, 0);
      checkOutput("rstmid_sclk", sclk_adc, 0);
      checkOutput("rstmid_busy", busy, 0);
      checkOutput("rstmid_overrun", overrun_count, 0);
      checkOutput("rstmid_data", sample_data, 0);
      reset = 1'b0;
      r_cyc = cyc;
      waitFrameStart("rstmid_next_start", t1);
      checkOutput("rstmid_restart_latency", t1 - r_cyc, SP);
      checkOutput("rstmid_no_sample", samples_seen, snap);
      waitValid("rstmid_valid_after");
      checkOutput("rstmid_data_after", sample_data, 10'h155);
      checkOutput("rstmid_chan_after", sample_chan, 1);

      // Overrun saturation with the sample left unaccepted
      repeat (20000) step();
      checkOutput("overrun_200", overrun_count, 200);
      repeat (10050) step();
      checkOutput("overrun_saturated", overrun_count, 255);
      checkOutput("sat_data_held", sample_data, 10'h155);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/adc_sample_sequencer.md
ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

Interface
- REQ-001: Parameter CLK_DIV, default 8: clk cycles per sclkAdc half-period; legal range 2-255.
- REQ-002: Parameter SAMPLE_PERIOD, default 2500: clk cycles between sample ticks; legal only when SAMPLE_PERIOD > 34*CLK_DIV.
- REQ-003: clk  input  1  single system clock; all logic on posedge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: enable  input  1  1 = periodic sampling runs; 0 = no new frames start.
- REQ-006: chanSel  input  1  ADC channel for the next frame; latched at frame start.
- REQ-007: dinAdc  input  1  serial data from the ADC.
- REQ-008: sclkAdc  output  1  SPI clock to the ADC; idles low.
- REQ-009: doutAdc  output  1  serial command to the ADC.
- REQ-010: ncsAdc  output  1  active-low chip select to the ADC.
- REQ-011: sampleData  output  10  last captured conversion, MSB first on the wire.
- REQ-012: sampleChan  output  1  channel of sampleData.
- REQ-013: sampleValid  output  1  sample available to the downstream consumer (Pi link).
- REQ-014: sampleReady  input  1  downstream accepts the sample when sampleValid && sampleReady on a posedge.
- REQ-015: overrunCount  output  8  saturating count of skipped ticks.
- REQ-016: busy  output  1  high from frame start through end of HOLD.

Function
- REQ-017: Tick counter counts 0..SAMPLE_PERIOD-1 and wraps; tick = (count == SAMPLE_PERIOD-1) && enable; counter is held at 0 while enable = 0.
- REQ-018: States: IDLE, SHIFT, HOLD.
- REQ-019: IDLE, tick, and sampleValid = 0 -> SHIFT next cycle; chanSel is latched; ncsAdc = 0, sclkAdc = 0, doutAdc = frame bit 0.
- REQ-020: A tick in IDLE with sampleValid = 1, or any tick in SHIFT/HOLD, starts no frame and increments overrunCount, which saturates at 255.
- REQ-021: Frame: 16 sclkAdc periods; each low phase is CLK_DIV cycles, then each high phase is CLK_DIV cycles; the first rising edge occurs CLK_DIV cycles after ncsAdc falls.
- REQ-022: Command bits k = 0..15 on doutAdc: k0 = 1 (start), k1 = 1 (single-ended), k2 = latched chanSel, k3 = 1 (MSB-first), k4..k15 = 0.
- REQ-023: doutAdc changes only on the cycle sclkAdc falls (and at frame start); it is stable across every rising edge.
- REQ-024: dinAdc is sampled on the clk cycle sclkAdc rises; bits k6..k15 form sampleData[9:0], MSB first; bits k0..k5 are ignored.
- REQ-025: At the end of the 16th high phase, sclkAdc = 0 and ncsAdc = 1 on the same cycle, 32*CLK_DIV cycles after frame start.
- REQ-026: On that same cycle: sampleData and sampleChan load, sampleValid = 1, and the state moves to HOLD.
- REQ-027: HOLD: ncsAdc stays high for CLK_DIV cycles, then the state returns to IDLE.
- REQ-028: sampleValid clears on the cycle after a handshake.
- REQ-029: sampleData and sampleChan stay stable while sampleValid = 1 and are never overwritten before acceptance.
- REQ-030: enable falling mid-frame does not abort the frame; the frame completes and delivers its sample.
- REQ-031: sampleReady is ignored while sampleValid = 0.

Reset
- REQ-032: Reset asserted on any cycle, including mid-frame, forces these values on the next cycle: state IDLE, ncsAdc 1, sclkAdc 0, doutAdc 0, sampleValid 0, sampleData 0, sampleChan 0, overrunCount 0, busy 0, tick counter 0.
- REQ-033: A partial frame interrupted by reset produces no sample.
- REQ-034: The first tick after reset release occurs SAMPLE_PERIOD cycles later, provided enable = 1.

Verification
- REQ-035: CLK_DIV = 2, SAMPLE_PERIOD = 100, enable = 1, chanSel = 1, ADC model returns 0x2A5 -> ncsAdc low 64 cycles; doutAdc bits 1,1,1,1,0..0; sampleData = 0x2A5; sampleChan = 1; sampleValid rises with ncsAdc.
- REQ-036: sampleReady held 0 for 3 ticks after the first sample -> no new frames; overrunCount = 3; sampleData unchanged. Then raise sampleReady -> sampleValid drops next cycle; a new frame starts on the next tick.
- REQ-037: Reset pulsed at sclkAdc rising edge 7 -> next cycle ncsAdc = 1 and sampleValid = 0; no sample is delivered; the next frame starts 100 cycles after reset release.
- REQ-038: ADC model returns 0x3FF, then 0x000, with sampleReady = 1 -> two samples delivered exactly 100 cycles apart with values 0x3FF and 0x000; each handshake takes 1 cycle.
- REQ-039: enable dropped at bit 10 of a frame -> the frame completes; no further ncsAdc activity; overrunCount unchanged.
- REQ-040: 300 forced overruns -> overrunCount saturates at 255.
